status_display_ctrl: RTL and testbench

STATUS_DISPLAY_CTRL -- requirements
Module: status_display_ctrl

---
 rtl/status_display_ctrl_if.sv | 37 +++
 rtl/status_display_ctrl.sv | 228 ++++++++++++++++++++++
 tb/tb_status_display_ctrl.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/status_display_ctrl_if.sv
// Status display bus: system status and keypad inputs toward the controller,
// BCD display and LED drive back out of it.
interface status_display_ctrl_if #(
  parameter int unsigned DIG_N = 4,
  parameter int unsigned LED_N = 8
);
  logic                 train_active;
  logic                 train_done;
  logic [7:0]           epoch;
  logic                 submit;
  logic                 nn_y;
  logic [6:0]           prob_pct;
  logic                 key_valid;
  logic [3:0]           key_digit;
  logic [4*DIG_N-1:0]   idle_data;
  logic                 idle_valid;

  logic [4*DIG_N-1:0]   seg_data;
  logic                 seg_valid;
  logic                 seg_number_mode;
  logic [LED_N-1:0]     led;
  logic [2:0]           mode;

  // Side that supplies status and consumes the display drive.
  modport master (
    output train_active, train_done, epoch, submit, nn_y, prob_pct,
           key_valid, key_digit, idle_data, idle_valid,
    input  seg_data, seg_valid, seg_number_mode, led, mode
  );

  // The display controller itself.
  modport slave (
    input  train_active, train_done, epoch, submit, nn_y, prob_pct,
           key_valid, key_digit, idle_data, idle_valid,
    output seg_data, seg_valid, seg_number_mode, led, mode
  );
endinterface

// File: rtl/status_display_ctrl.sv
// Status display controller: arbitrates between idle pass-through, keypad
// echo, classifier result, training progress and training-done overlays, and
// drives a BCD display plus an LED bar. All outputs are registered.
module status_display_ctrl #(
  parameter int unsigned DIG_N           = 4,
  parameter int unsigned LED_N           = 8,
  parameter int unsigned DONE_HOLD_CYC   = 150000000,
  parameter int unsigned RESULT_HOLD_CYC = 150000000,
  parameter int unsigned KEY_HOLD_CYC    = 25000000,
  parameter int unsigned ANIM_STEP_CYC   = 500000
) (
  input logic                  clk,
  input logic                  rst,
  status_display_ctrl_if.slave bus_io
);

  // Display needs at least three digits and the LED bar at least two LEDs.
  localparam int unsigned SegW  = 4 * DIG_N;
  localparam int unsigned DoneW = $clog2(DONE_HOLD_CYC + 1);
  localparam int unsigned ResW  = $clog2(RESULT_HOLD_CYC + 1);
  localparam int unsigned KeyW  = $clog2(KEY_HOLD_CYC + 1);
  localparam int unsigned AnimW = $clog2(ANIM_STEP_CYC + 1);

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StKey    = 3'd1,
    StResult = 3'd2,
    StTrain  = 3'd3,
    StDone   = 3'd4
  } state_e;

  state_e state_q, state_d;

  // Edge detection; arm_q blocks edges on the first cycle after reset so a
  // level already high at release is not mistaken for a rising edge.
  logic submit_q, train_done_q, arm_q;
  logic submit_rise, done_rise;

  logic [DoneW-1:0] done_tmr_q, done_tmr_d;
  logic [ResW-1:0]  res_tmr_q, res_tmr_d;
  logic [KeyW-1:0]  key_tmr_q, key_tmr_d;
  logic [AnimW-1:0] anim_tmr_q, anim_tmr_d;
  logic [LED_N-1:0] anim_pos_q, anim_pos_d;

  logic [6:0] prob_q, prob_d;
  logic       y_q, y_d;
  logic [3:0] key_q, key_d;
  logic [6:0] prob_clamped;

  logic [SegW-1:0]  seg_q, seg_d;
  logic             seg_valid_q, seg_valid_d;
  logic             num_mode_q, num_mode_d;
  logic [LED_N-1:0] led_q, led_d;
  logic [2:0]       mode_q, mode_d;

  // Binary 0..255 to three BCD digits.
  function automatic logic [11:0] to_bcd3(input logic [7:0] v);
    return {4'(v / 8'd100), 4'((v % 8'd100) / 8'd10), 4'(v % 8'd10)};
  endfunction

  // Thermometer bar of max(1, floor(p * (LED_N-1) / 100)) lit segments.
  function automatic logic [LED_N-2:0] therm_bars(input logic [6:0] p);
    int unsigned      cnt;
    logic [LED_N-2:0] ones;
    cnt  = (32'(p) * (LED_N - 1)) / 32'd100;
    if (cnt == 0) begin
      cnt = 1;
    end
    ones = '1;
    return ~(ones << cnt);
  endfunction

  assign submit_rise  = arm_q & bus_io.submit & ~submit_q;
  assign done_rise    = arm_q & bus_io.train_done & ~train_done_q;
  assign prob_clamped = (bus_io.prob_pct > 7'd100) ? 7'd100 : bus_io.prob_pct;

  // Next state, timers and latches; timers default to zero so every state
  // entry or retrigger restarts them, and only a stay increments them.
  always_comb begin
    state_d    = state_q;
    done_tmr_d = '0;
    res_tmr_d  = '0;
    key_tmr_d  = '0;
    anim_tmr_d = '0;
    anim_pos_d = LED_N'(1);
    prob_d     = prob_q;
    y_d        = y_q;
    key_d      = key_q;

    if (done_rise) begin
      state_d = StDone;
    end else if (state_q == StDone) begin
      if (done_tmr_q == DoneW'(DONE_HOLD_CYC - 1)) begin
        state_d = bus_io.train_active ? StTrain : StIdle;
      end else begin
        done_tmr_d = done_tmr_q + DoneW'(1);
      end
    end else if (bus_io.train_active) begin
      // Training preempts any overlay and drops what it was showing.
      state_d = StTrain;
      prob_d  = '0;
      y_d     = 1'b0;
      key_d   = '0;
      if (state_q == StTrain) begin
        if (anim_tmr_q == AnimW'(ANIM_STEP_CYC - 1)) begin
          anim_pos_d = {anim_pos_q[LED_N-2:0], anim_pos_q[LED_N-1]};
        end else begin
          anim_tmr_d = anim_tmr_q + AnimW'(1);
          anim_pos_d = anim_pos_q;
        end
      end
    end else if (state_q == StTrain) begin
      state_d = StIdle;
    end else if (submit_rise) begin
      state_d = StResult;
      prob_d  = prob_clamped;
      y_d     = bus_io.nn_y;
    end else if (bus_io.key_valid && (state_q != StResult)) begin
      state_d = StKey;
      key_d   = bus_io.key_digit;
    end else if (state_q == StResult) begin
      if (res_tmr_q == ResW'(RESULT_HOLD_CYC - 1)) begin
        state_d = StIdle;
      end else begin
        res_tmr_d = res_tmr_q + ResW'(1);
      end
    end else if (state_q == StKey) begin
      if (key_tmr_q == KeyW'(KEY_HOLD_CYC - 1)) begin
        state_d = StIdle;
      end else begin
        key_tmr_d = key_tmr_q + KeyW'(1);
      end
    end
  end

  // Output image for the upcoming state, so outputs trail inputs by one cycle.
  always_comb begin
    seg_d       = '0;
    seg_valid_d = 1'b0;
    num_mode_d  = 1'b0;
    led_d       = '0;
    mode_d      = state_d;
    case (state_d)
      StDone: begin
        seg_d[7:0]  = 8'h99;
        seg_valid_d = 1'b1;
        num_mode_d  = 1'b1;
        led_d       = '1;
      end
      StTrain: begin
        seg_d[11:0] = to_bcd3(bus_io.epoch);
        seg_valid_d = 1'b1;
        num_mode_d  = 1'b1;
        led_d       = anim_pos_d;
      end
      StResult: begin
        seg_d[11:0] = to_bcd3({1'b0, prob_d});
        seg_valid_d = 1'b1;
        num_mode_d  = 1'b1;
        led_d       = {y_d, therm_bars(prob_d)};
      end
      StKey: begin
        seg_d[3:0]  = key_d;
        seg_valid_d = 1'b1;
        num_mode_d  = 1'b1;
      end
      default: begin
        seg_d       = bus_io.idle_data;
        seg_valid_d = bus_io.idle_valid;
      end
    endcase
  end

  // State, timers, latches and edge history.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= StIdle;
      submit_q     <= 1'b0;
      train_done_q <= 1'b0;
      arm_q        <= 1'b0;
      done_tmr_q   <= '0;
      res_tmr_q    <= '0;
      key_tmr_q    <= '0;
      anim_tmr_q   <= '0;
      anim_pos_q   <= '0;
      prob_q       <= '0;
      y_q          <= 1'b0;
      key_q        <= '0;
    end else begin
      state_q      <= state_d;
      submit_q     <= bus_io.submit;
      train_done_q <= bus_io.train_done;
      arm_q        <= 1'b1;
      done_tmr_q   <= done_tmr_d;
      res_tmr_q    <= res_tmr_d;
      key_tmr_q    <= key_tmr_d;
      anim_tmr_q   <= anim_tmr_d;
      anim_pos_q   <= anim_pos_d;
      prob_q       <= prob_d;
      y_q          <= y_d;
      key_q        <= key_d;
    end
  end

  // Registered display and LED outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      seg_q       <= '0;
      seg_valid_q <= 1'b0;
      num_mode_q  <= 1'b0;
      led_q       <= '0;
      mode_q      <= '0;
    end else begin
      seg_q       <= seg_d;
      seg_valid_q <= seg_valid_d;
      num_mode_q  <= num_mode_d;
      led_q       <= led_d;
      mode_q      <= mode_d;
    end
  end

  assign bus_io.seg_data        = seg_q;
  assign bus_io.seg_valid       = seg_valid_q;
  assign bus_io.seg_number_mode = num_mode_q;
  assign bus_io.led             = led_q;
  assign bus_io.mode            = mode_q;

endmodule

// File: tb/tb_status_display_ctrl.sv
// Directed bench for status_display_ctrl with short hold times.
module tb_status_display_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  status_display_ctrl_if #(.DIG_N(4), .LED_N(8)) bus ();

  status_display_ctrl #(
    .DIG_N          (4),
    .LED_N          (8),
    .DONE_HOLD_CYC  (10),
    .RESULT_HOLD_CYC(8),
    .KEY_HOLD_CYC   (5),
    .ANIM_STEP_CYC  (3)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .bus_io(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ta;
    logic        td;
    logic [7:0]  ep;
    logic        sb;
    logic        y;
    logic [6:0]  p;
    logic        kv;
    logic [3:0]  kd;
    logic [15:0] idata;
    logic        ivalid;
    logic [15:0] seg;
    logic        v;
    logic        nm;
    logic [7:0]  led;
    logic [2:0]  mode;
  } vec_t;

  vec_t tab[10];

  function automatic vec_t mk(input logic ta, td, input logic [7:0] ep, input logic sb, y,
                              input logic [6:0] p, input logic kv, input logic [3:0] kd,
                              input logic [15:0] idata, input logic ivalid,
                              input logic [15:0] seg, input logic v, nm,
                              input logic [7:0] led, input logic [2:0] mode);
    vec_t r;
    r.ta = ta; r.td = td; r.ep = ep; r.sb = sb; r.y = y; r.p = p; r.kv = kv; r.kd = kd;
    r.idata = idata; r.ivalid = ivalid;
    r.seg = seg; r.v = v; r.nm = nm; r.led = led; r.mode = mode;
    return r;
  endfunction

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic ta, td, input logic [7:0] ep, input logic sb, y,
                       input logic [6:0] p, input logic kv, input logic [3:0] kd);
    bus.train_active = ta;
    bus.train_done   = td;
    bus.epoch        = ep;
    bus.submit       = sb;
    bus.nn_y         = y;
    bus.prob_pct     = p;
    bus.key_valid    = kv;
    bus.key_digit    = kd;
  endtask

  task automatic check(input string name, input logic [15:0] seg_e, input logic v_e,
                       input logic nm_e, input logic [7:0] led_e, input logic [2:0] mode_e);
    n_checks++;
    if (bus.seg_data === seg_e && bus.seg_valid === v_e && bus.seg_number_mode === nm_e &&
        bus.led === led_e && bus.mode === mode_e) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got seg=%h valid=%b num=%b led=%h mode=%0d, want seg=%h valid=%b num=%b led=%h mode=%0d",
               name, bus.seg_data, bus.seg_valid, bus.seg_number_mode, bus.led, bus.mode,
               seg_e, v_e, nm_e, led_e, mode_e);
    end
  endtask

  task automatic chk_idle(input string name);
    check(name, 16'h1234, 1'b1, 1'b0, 8'h00, 3'd0);
  endtask

  task automatic chk_done(input string name);
    check(name, 16'h0099, 1'b1, 1'b1, 8'hFF, 3'd4);
  endtask

  task automatic chk_key(input string name, input logic [3:0] d);
    check(name, {12'h000, d}, 1'b1, 1'b1, 8'h00, 3'd1);
  endtask

  initial begin
    logic [15:0] exp_seg;
    logic [7:0]  exp_led;

    drive(1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 7'd0, 1'b0, 4'd0);
    bus.idle_data  = 16'h1234;
    bus.idle_valid = 1'b1;
    @(negedge clk);
    cyc();
    check("reset0", 16'h0000, 1'b0, 1'b0, 8'h00, 3'd0);
    cyc();
    check("reset1", 16'h0000, 1'b0, 1'b0, 8'h00, 3'd0);
    rst = 1'b1;

    // Idle pass-through, result latching, clamping and key-in-result.
    tab[0] = mk(0, 0, 0, 0, 0, 7'd0,   0, 0, 16'h1234, 1, 16'h1234, 1, 0, 8'h00, 3'd0);
    tab[1] = mk(0, 0, 0, 0, 0, 7'd0,   0, 0, 16'hABCD, 0, 16'hABCD, 0, 0, 8'h00, 3'd0);
    tab[2] = mk(0, 0, 0, 1, 1, 7'd73,  0, 0, 16'hABCD, 0, 16'h0073, 1, 1, 8'h9F, 3'd2);
    tab[3] = mk(0, 0, 0, 1, 1, 7'd10,  0, 0, 16'hABCD, 0, 16'h0073, 1, 1, 8'h9F, 3'd2);
    tab[4] = mk(0, 0, 0, 0, 1, 7'd0,   0, 0, 16'hABCD, 0, 16'h0073, 1, 1, 8'h9F, 3'd2);
    tab[5] = mk(0, 0, 0, 1, 0, 7'd0,   0, 0, 16'hABCD, 0, 16'h0000, 1, 1, 8'h01, 3'd2);
    tab[6] = mk(0, 0, 0, 0, 0, 7'd0,   1, 5, 16'hABCD, 0, 16'h0000, 1, 1, 8'h01, 3'd2);
    tab[7] = mk(0, 0, 0, 1, 1, 7'd120, 1, 5, 16'hABCD, 0, 16'h0100, 1, 1, 8'hFF, 3'd2);
    tab[8] = mk(0, 0, 0, 0, 1, 7'd120, 0, 0, 16'hABCD, 0, 16'h0100, 1, 1, 8'hFF, 3'd2);
    tab[9] = mk(0, 0, 0, 0, 0, 7'd0,   0, 0, 16'h1234, 1, 16'h0100, 1, 1, 8'hFF, 3'd2);
    for (int i = 0; i < 10; i++) begin
      drive(tab[i].ta, tab[i].td, tab[i].ep, tab[i].sb, tab[i].y, tab[i].p, tab[i].kv,
            tab[i].kd);
      bus.idle_data  = tab[i].idata;
      bus.idle_valid = tab[i].ivalid;
      cyc();
      check($sformatf("vec%0d", i), tab[i].seg, tab[i].v, tab[i].nm, tab[i].led, tab[i].mode);
    end
    // Result entered at vec7 holds 8 cycles in total.
    for (int k = 3; k < 8; k++) begin
      cyc();
      check($sformatf("res_hold%0d", k), 16'h0100, 1'b1, 1'b1, 8'hFF, 3'd2);
    end
    cyc();
    chk_idle("res_expire");

    // Result, then training aborts it; LED walks and wraps.
    drive(1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 7'd50, 1'b0, 4'd0);
    cyc();
    check("res50", 16'h0050, 1'b1, 1'b1, 8'h07, 3'd2);
    drive(1'b1, 1'b0, 8'd12, 1'b0, 1'b0, 7'd0, 1'b0, 4'd0);
    cyc();
    check("train0", 16'h0012, 1'b1, 1'b1, 8'h01, 3'd3);
    for (int k = 1; k < 28; k++) begin
      bus.submit    = (k == 10);
      bus.key_valid = (k == 10);
      exp_seg = 16'h0012;
      if (k == 25) begin
        bus.epoch = 8'd255;
        exp_seg   = 16'h0255;
      end else if (k == 26) begin
        bus.epoch = 8'd7;
        exp_seg   = 16'h0007;
      end else if (k == 27) begin
        bus.epoch = 8'd200;
        exp_seg   = 16'h0200;
      end
      exp_led = 8'h01 << ((k / 3) % 8);
      cyc();
      check($sformatf("train%0d", k), exp_seg, 1'b1, 1'b1, exp_led, 3'd3);
    end
    bus.submit       = 1'b0;
    bus.key_valid    = 1'b0;
    bus.train_active = 1'b0;
    cyc();
    chk_idle("train_exit");
    cyc();
    chk_idle("no_restore");

    // Key press, second press 4 cycles later restarts the 5-cycle hold.
    drive(1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 7'd0, 1'b1, 4'd7);
    cyc();
    chk_key("key7", 4'd7);
    bus.key_valid = 1'b0;
    for (int k = 1; k < 4; k++) begin
      cyc();
      chk_key($sformatf("key7_%0d", k), 4'd7);
    end
    bus.key_valid = 1'b1;
    bus.key_digit = 4'd3;
    cyc();
    chk_key("key3", 4'd3);
    bus.key_valid = 1'b0;
    for (int k = 1; k < 5; k++) begin
      cyc();
      chk_key($sformatf("key3_%0d", k), 4'd3);
    end
    cyc();
    chk_idle("key_expire");

    // Retrigger on the exact expiry cycle wins over expiry.
    bus.key_valid = 1'b1;
    bus.key_digit = 4'd1;
    cyc();
    chk_key("key1", 4'd1);
    bus.key_valid = 1'b0;
    for (int k = 1; k < 5; k++) begin
      cyc();
      chk_key($sformatf("key1_%0d", k), 4'd1);
    end
    bus.key_valid = 1'b1;
    bus.key_digit = 4'd9;
    cyc();
    chk_key("key9_retrig", 4'd9);
    bus.key_valid = 1'b0;
    for (int k = 1; k < 5; k++) begin
      cyc();
      chk_key($sformatf("key9_%0d", k), 4'd9);
    end
    cyc();
    chk_idle("key9_expire");

    // Done overlay for exactly 10 cycles with train_done held as a level.
    bus.train_done = 1'b1;
    for (int k = 0; k < 10; k++) begin
      cyc();
      chk_done($sformatf("done%0d", k));
    end
    cyc();
    chk_idle("done_expire");
    bus.train_done = 1'b0;
    cyc();
    chk_idle("done_low");

    // Done retriggered mid-hold, then exits to training.
    bus.train_done = 1'b1;
    cyc();
    chk_done("dretrig0");
    bus.train_done = 1'b0;
    for (int k = 1; k < 5; k++) begin
      cyc();
      chk_done($sformatf("dretrig%0d", k));
    end
    bus.train_done   = 1'b1;
    bus.train_active = 1'b1;
    bus.epoch        = 8'd42;
    for (int k = 5; k < 15; k++) begin
      cyc();
      chk_done($sformatf("dretrig%0d", k));
    end
    cyc();
    check("done_to_train", 16'h0042, 1'b1, 1'b1, 8'h01, 3'd3);
    bus.train_active = 1'b0;
    bus.train_done   = 1'b0;
    cyc();
    chk_idle("train_off");

    // Simultaneous done and submit rise: submit is dropped.
    drive(1'b0, 1'b1, 8'd0, 1'b1, 1'b1, 7'd40, 1'b0, 4'd0);
    for (int k = 0; k < 10; k++) begin
      cyc();
      chk_done($sformatf("dsub%0d", k));
    end
    cyc();
    chk_idle("dsub_idle");
    drive(1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 7'd0, 1'b0, 4'd0);
    cyc();
    chk_idle("dsub_low");

    // Reset mid-done with train_done and submit held across release.
    bus.train_done = 1'b1;
    cyc();
    chk_done("pre_rst0");
    cyc();
    chk_done("pre_rst1");
    bus.idle_data  = 16'h0000;
    bus.idle_valid = 1'b0;
    bus.submit     = 1'b1;
    rst            = 1'b0;
    cyc();
    check("in_rst0", 16'h0000, 1'b0, 1'b0, 8'h00, 3'd0);
    cyc();
    check("in_rst1", 16'h0000, 1'b0, 1'b0, 8'h00, 3'd0);
    rst = 1'b1;
    for (int k = 0; k < 12; k++) begin
      cyc();
      check($sformatf("post_rst%0d", k), 16'h0000, 1'b0, 1'b0, 8'h00, 3'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
